// File: rtl/core_csr_unit_timer.sv
// Shared cycle/time/instret counter for a single-hart core.
// It free-runs by one per clock, and a write replaces the count for that edge.
module core_csr_unit_timer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] val_o,
    input  logic [WIDTH-1:0] val_i,
    input  logic             we_i
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt;

    // A write takes priority over the increment; wrap-around is plain modulo arithmetic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (we_i) begin
            cnt <= val_i;
        end else begin
            cnt <= cnt + ONE;
        end
    end

    assign val_o = cnt;

endmodule

// File: tb/tb_core_csr_unit_timer.sv
// Directed self-checking bench for core_csr_unit_timer.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_core_csr_unit_timer;

    localparam int WIDTH = 64;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] val_o;
    logic [WIDTH-1:0] val_i;
    logic             we_i;

    int check_count = 0;
    int error_count = 0;

    core_csr_unit_timer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .val_o (val_o),
        .val_i (val_i),
        .we_i  (we_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, actual, expected);
        end
    endtask

    // Advance one rising edge and settle just past it
    task automatic applyStimulus(input logic we, input logic [WIDTH-1:0] val);
        we_i  = we;
        val_i = val;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        we_i  = 1'b0;
        val_i = '0;
        #1;
        checkOutput("reset_initial", val_o, 64'h0);
        applyStimulus(1'b1, 64'h1234);
        applyStimulus(1'b0, 64'h0);
        checkOutput("reset_held", val_o, 64'h0);

        // Free run from reset: first edge after release increments to 1
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 64'h0);
            checkOutput($sformatf("free_run_%0d", i), val_o, 64'(i));
        end

        applyStimulus(1'b1, 64'h0000_0001_0000_0000);
        checkOutput("load", val_o, 64'h0000_0001_0000_0000);
        applyStimulus(1'b0, 64'h0);
        checkOutput("load_inc1", val_o, 64'h0000_0001_0000_0001);
        applyStimulus(1'b0, 64'h0);
        checkOutput("load_inc2", val_o, 64'h0000_0001_0000_0002);

        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("wrap_load", val_o, 64'hFFFF_FFFF_FFFF_FFFE);
        applyStimulus(1'b0, 64'h0);
        checkOutput("wrap_max", val_o, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(1'b0, 64'h0);
        checkOutput("wrap_zero", val_o, 64'h0);

        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("load_all_ones", val_o, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(1'b0, 64'h0);
        checkOutput("all_ones_wrap", val_o, 64'h0);

        applyStimulus(1'b1, 64'h10);
        checkOutput("held_load_10", val_o, 64'h10);
        applyStimulus(1'b1, 64'h20);
        checkOutput("held_load_20", val_o, 64'h20);
        applyStimulus(1'b1, 64'h30);
        checkOutput("held_load_30", val_o, 64'h30);
        applyStimulus(1'b0, 64'h0);
        checkOutput("held_load_resume", val_o, 64'h31);

        applyStimulus(1'b1, 64'h0000_0000_FFFF_FFFF);
        checkOutput("half_load", val_o, 64'h0000_0000_FFFF_FFFF);
        applyStimulus(1'b0, 64'h0);
        checkOutput("half_carry", val_o, 64'h0000_0001_0000_0000);

        // Count up to 0x100, then drop reset between edges
        applyStimulus(1'b1, 64'hF0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 64'h0);
        checkOutput("count_to_100", val_o, 64'h100);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_immediate", val_o, 64'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 64'hABCD);
            checkOutput($sformatf("reset_hold_we_%0d", i), val_o, 64'h0);
        end

        // First edge after release with a write pending loads instead of incrementing
        rst_n = 1'b1;
        applyStimulus(1'b1, 64'hABCD);
        checkOutput("release_load", val_o, 64'hABCD);
        applyStimulus(1'b0, 64'h0);
        checkOutput("release_load_inc", val_o, 64'hABCE);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
